dcache_wb_buffer: RTL and testbench
===================================

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 4, number of write-back entries (power of two, ≥2).
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (state cleared while 0).
REQ-004 SHALL have port evict_en  in  1  Dcache fill this cycle (wr1_from_mem & wr1_en & !wr1_hit_out).
REQ-005 SHALL have port evict_valid  in  1  victim line valid.
REQ-006 SHALL have port evict_dirty  in  1  victim line dirty.
REQ-007 SHALL have port evict_addr  in  SASS_ADDR  victim tag/set_index.
REQ-008 SHALL have port evict_data  in  64  victim line data.
REQ-009 SHALL have port wb_full  out  1  no free entry; Dcache fill stalls.
REQ-010 SHALL have port rd_addr  in  SASS_ADDR  load-miss lookup address.
REQ-011 SHALL have port rd_hit  out  1  rd_addr matches a buffered entry.
REQ-012 SHALL have port rd_data  out  64  data of matching entry.
REQ-013 SHALL have port mem_grant  in  1  memory arbiter grants bus to this block.
REQ-014 SHALL have port proc2mem_command  out  BUS_COMMAND  BUS_STORE or BUS_NONE.
REQ-015 SHALL have port proc2mem_addr  out  64  {tag, set_index, 3'b0}.
REQ-016 SHALL have port proc2mem_data  out  64  store data.
REQ-017 SHALL have port mem2proc_response  in  4  nonzero = store accepted this cycle.
REQ-018 SHALL have port flush_req  in  1  one-cycle pulse: drain everything.
REQ-019 SHALL have port flush_done  out  1  one-cycle pulse when flush completes.

Function
REQ-020 SHALL be a circular FIFO: head, tail pointers of $clog2(WB_DEPTH) bits wrapping modulo WB_DEPTH, count of $clog2(WB_DEPTH)+1 bits.
REQ-021 SHALL push when evict_en & evict_valid & evict_dirty & !wb_full; clean or invalid victims are dropped.
REQ-022 SHALL assert wb_full combinationally from registered count == WB_DEPTH; push while full is ignored even if a pop occurs that cycle.
REQ-023 SHALL coalesce: push whose address matches a valid non-head-popping entry overwrites that entry's data, no pointer/count change.
REQ-024 SHALL treat a push matching the head entry popped in the same cycle as a new entry.
REQ-025 SHALL drive proc2mem_command=BUS_STORE with head addr/data when state≠IDLE-empty, count>0 and mem_grant; else BUS_NONE, addr/data 0.
REQ-026 SHALL pop head when BUS_STORE driven and mem2proc_response≠0; otherwise hold and retry next cycle.
REQ-027 SHALL permit push and pop in one cycle: count unchanged.
REQ-028 SHALL compute rd_hit/rd_data combinationally over registered valid entries; multiple matches impossible (coalescing); entry popping this cycle still hits.
REQ-029 SHALL have FSM states IDLE (count==0), DRAIN (count>0), FLUSH; IDLE->DRAIN on push; DRAIN->IDLE when count reaches 0; any->FLUSH on flush_req.
REQ-030 SHALL in FLUSH reject pushes (wb_full forced 1), drain, then pulse flush_done one cycle after count reaches 0 and return to IDLE.
REQ-031 SHALL on flush_req with count==0 pulse flush_done next cycle.
REQ-032 SHALL add zero latency: entry pushed at edge N is presented to memory from cycle N+1.

Reset
REQ-033 SHALL while reset==0 asynchronously clear head, tail, count, all valid bits, FSM to IDLE; outputs: wb_full=0, rd_hit=0, rd_data=0, proc2mem_command=BUS_NONE, addr/data=0, flush_done=0.
REQ-034 SHALL discard in-flight store on reset mid-transfer; no retry after release.

Structure
REQ-035 SHALL take SASS_ADDR, BUS_COMMAND and new WB_ENTRY_t {valid, SASS_ADDR addr, data[63:0]}, WB_STATE_t from the shared package.
REQ-036 SHALL place the address-match CAM in one sub-module wb_cam (WB_DEPTH match vector + one-hot index).

Verification
REQ-037 SHALL test: reset, one dirty push addr tag=5/set=2 data=0xAA, grant=1, response=3 -> BUS_STORE addr {5,2,000} at N+1, count 0 at N+2.
REQ-038 SHALL test: 4 dirty pushes, no grant -> wb_full=1, 5th push dropped; one accept -> wb_full=0.
REQ-039 SHALL test: push X data=1 then X data=2 -> count 1, rd_addr=X gives rd_hit=1, rd_data=2.
REQ-040 SHALL test: full buffer, simultaneous push+accept -> push dropped, count=3.
REQ-041 SHALL test: 3 entries, flush_req, response=0 two cycles then nonzero -> pushes rejected, flush_done exactly once after last pop.
REQ-042 SHALL test: reset=0 mid BUS_STORE with response=0 -> command BUS_NONE immediately, count 0, rd_hit=0.

Source files
------------

// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the Dcache write-back buffer: victim address, bus command,
// buffer entry and controller state.
package dcache_wb_buffer_pkg;

  localparam int unsigned TAG_W = 8;
  localparam int unsigned SET_W = 5;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set_index;
  } SASS_ADDR;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic        valid;
    SASS_ADDR    addr;
    logic [63:0] data;
  } WB_ENTRY_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_FLUSH = 2'd2
  } WB_STATE_t;

  // Line-aligned byte address of a victim line.
  function automatic logic [63:0] wb_bus_addr(SASS_ADDR a);
    return 64'({a.tag, a.set_index, 3'b000});
  endfunction

endpackage

// File: rtl/dcache_wb_buffer_cam.sv
// Address-match CAM over the write-back entries: per-entry match vector plus
// the index of the (unique) matching entry.
module wb_cam
  import dcache_wb_buffer_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4,
  parameter int unsigned IDX_W    = $clog2(WB_DEPTH)
) (
  input  WB_ENTRY_t [WB_DEPTH-1:0] entries_i,
  input  SASS_ADDR                 key_i,
  output logic [WB_DEPTH-1:0]      match_o,
  output logic [IDX_W-1:0]         idx_o
);

  always_comb begin
    match_o = '0;
    idx_o   = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (entries_i[i].valid && (entries_i[i].addr == key_i)) begin
        match_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Circular write-back buffer between the Dcache and memory: absorbs dirty
// victims, coalesces repeats, serves load-miss lookups and drains on flush.
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        evict_en,
  input  logic        evict_valid,
  input  logic        evict_dirty,
  input  SASS_ADDR    evict_addr,
  input  logic [63:0] evict_data,
  output logic        wb_full,
  input  SASS_ADDR    rd_addr,
  output logic        rd_hit,
  output logic [63:0] rd_data,
  input  logic        mem_grant,
  output BUS_COMMAND  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic        flush_req,
  output logic        flush_done
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);

  WB_ENTRY_t [WB_DEPTH-1:0] buf_q, buf_d;
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]           count_q, count_d;
  WB_STATE_t                state_q, state_d;

  logic [WB_DEPTH-1:0] rd_match, wr_match;
  logic [PTR_W-1:0]    rd_idx, wr_idx;
  logic                issue, pop, push, coalesce, push_new;

  wb_cam #(.WB_DEPTH(WB_DEPTH)) u_rd_cam (
    .entries_i (buf_q),
    .key_i     (rd_addr),
    .match_o   (rd_match),
    .idx_o     (rd_idx)
  );

  wb_cam #(.WB_DEPTH(WB_DEPTH)) u_wr_cam (
    .entries_i (buf_q),
    .key_i     (evict_addr),
    .match_o   (wr_match),
    .idx_o     (wr_idx)
  );

  assign issue    = (count_q != '0) && mem_grant;
  assign pop      = issue && (mem2proc_response != '0);
  assign wb_full  = (count_q == (PTR_W+1)'(WB_DEPTH)) || (state_q == WB_FLUSH);
  assign push     = evict_en && evict_valid && evict_dirty && !wb_full;
  // A match on the head that leaves this cycle must become a fresh tail entry.
  assign coalesce = (|wr_match) && !(pop && wr_match[head_q]);
  assign push_new = push && !coalesce;

  assign proc2mem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = issue ? wb_bus_addr(buf_q[head_q].addr) : '0;
  assign proc2mem_data    = issue ? buf_q[head_q].data : '0;
  assign rd_hit           = |rd_match;
  assign rd_data          = rd_hit ? buf_q[rd_idx].data : '0;
  assign flush_done       = (state_q == WB_FLUSH) && (count_q == '0);

  always_comb begin
    buf_d   = buf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push && coalesce) begin
      buf_d[wr_idx].data = evict_data;
    end
    if (pop) begin
      buf_d[head_q].valid = 1'b0;
      head_d              = head_q + 1'b1;
    end
    if (push_new) begin
      buf_d[tail_q] = '{valid: 1'b1, addr: evict_addr, data: evict_data};
      tail_d        = tail_q + 1'b1;
    end
    if (push_new && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_new && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE:  if (push) state_d = WB_DRAIN;
      WB_DRAIN: if (count_d == '0) state_d = WB_IDLE;
      WB_FLUSH: if (count_q == '0) state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
    if (flush_req) begin
      state_d = WB_FLUSH;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= WB_IDLE;
    end else begin
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_dcache_wb_buffer;
  import dcache_wb_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        evict_en = 1'b0, evict_valid = 1'b0, evict_dirty = 1'b0;
  SASS_ADDR    evict_addr = '0;
  logic [63:0] evict_data = '0;
  logic        wb_full;
  SASS_ADDR    rd_addr = '0;
  logic        rd_hit;
  logic [63:0] rd_data;
  logic        mem_grant = 1'b0;
  BUS_COMMAND  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response = '0;
  logic        flush_req = 1'b0;
  logic        flush_done;

  dcache_wb_buffer #(.WB_DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .evict_en          (evict_en),
    .evict_valid       (evict_valid),
    .evict_dirty       (evict_dirty),
    .evict_addr        (evict_addr),
    .evict_data        (evict_data),
    .wb_full           (wb_full),
    .rd_addr           (rd_addr),
    .rd_hit            (rd_hit),
    .rd_data           (rd_data),
    .mem_grant         (mem_grant),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .flush_req         (flush_req),
    .flush_done        (flush_done)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic en, vld, dty;
    SASS_ADDR a;
    logic [63:0] d;
    logic g;
    logic [3:0] r;
    logic fl;
    SASS_ADDR ra;
  } in_t;

  typedef struct {
    in_t i;
    logic full, st;
    logic [63:0] pa, pd;
    logic hit;
    logic [63:0] rd;
    logic done;
  } vec_t;

  typedef struct { SASS_ADDR a; logic [63:0] d; } ment_t;

  ment_t       mq[$];
  bit          m_flush = 1'b0;
  int unsigned n_cmp = 0, n_bad = 0;

  function automatic SASS_ADDR mka(int unsigned tag, int unsigned set);
    SASS_ADDR a;
    a.tag       = 8'(tag);
    a.set_index = 5'(set);
    return a;
  endfunction

  function automatic logic [63:0] line_addr(SASS_ADDR a);
    return 64'(a.tag) * 64'd256 + 64'(a.set_index) * 64'd8;
  endfunction

  function automatic in_t mk_in(logic en, logic dty, SASS_ADDR a, logic [63:0] d,
                                logic g, logic [3:0] r, logic fl, SASS_ADDR ra);
    in_t x;
    x.en = en; x.vld = 1'b1; x.dty = dty; x.a = a; x.d = d;
    x.g = g; x.r = r; x.fl = fl; x.ra = ra;
    return x;
  endfunction

  function automatic vec_t mk_vec(in_t x, logic full, logic st, logic [63:0] pa,
                                  logic [63:0] pd, logic hit, logic [63:0] rd, logic done);
    vec_t v;
    v.i = x; v.full = full; v.st = st; v.pa = pa; v.pd = pd;
    v.hit = hit; v.rd = rd; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic        e_full, e_st, e_hit, e_done;
    logic [63:0] e_pa, e_pd, e_rd;
    e_full = m_flush || (mq.size() == DEPTH);
    e_st   = (mq.size() != 0) && mem_grant;
    e_pa   = e_st ? line_addr(mq[0].a) : 64'd0;
    e_pd   = e_st ? mq[0].d : 64'd0;
    e_done = m_flush && (mq.size() == 0);
    e_hit  = 1'b0;
    e_rd   = 64'd0;
    foreach (mq[i]) if (mq[i].a == rd_addr) begin e_hit = 1'b1; e_rd = mq[i].d; end
    chk("wb_full", 64'(wb_full), 64'(e_full));
    chk("command", 64'(proc2mem_command), e_st ? 64'(BUS_STORE) : 64'(BUS_NONE));
    chk("p2m_addr", proc2mem_addr, e_pa);
    chk("p2m_data", proc2mem_data, e_pd);
    chk("rd_hit", 64'(rd_hit), 64'(e_hit));
    chk("rd_data", rd_data, e_rd);
    chk("flush_done", 64'(flush_done), 64'(e_done));
  endtask

  task automatic model_update();
    bit    full, pop, was_empty;
    int    idx;
    ment_t e;
    full      = m_flush || (mq.size() == DEPTH);
    pop       = (mq.size() != 0) && mem_grant && (mem2proc_response != 0);
    was_empty = (mq.size() == 0);
    if (evict_en && evict_valid && evict_dirty && !full) begin
      idx = -1;
      for (int i = (pop ? 1 : 0); i < mq.size(); i++) if (mq[i].a == evict_addr) idx = i;
      if (idx >= 0) mq[idx].d = evict_data;
      else begin e.a = evict_addr; e.d = evict_data; mq.push_back(e); end
    end
    if (pop) void'(mq.pop_front());
    if (flush_req) m_flush = 1'b1;
    else if (m_flush && was_empty) m_flush = 1'b0;
  endtask

  task automatic apply(input in_t x);
    @(negedge clock);
    evict_en = x.en; evict_valid = x.vld; evict_dirty = x.dty;
    evict_addr = x.a; evict_data = x.d; mem_grant = x.g;
    mem2proc_response = x.r; flush_req = x.fl; rd_addr = x.ra;
    #2;
    model_check();
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    evict_en = 1'b0; flush_req = 1'b0; mem_grant = 1'b1; mem2proc_response = 4'h1;
    mq.delete();
    m_flush = 1'b0;
    #2;
    model_check();
    @(negedge clock);
    reset = 1'b1;
  endtask

  vec_t        tbl[8];
  SASS_ADDR    A, X, Z;
  int unsigned done_cnt;

  initial begin
    A = mka(5, 2);
    X = mka(8'h12, 7);
    Z = mka(0, 0);
    tbl[0] = mk_vec(mk_in(1, 1, A, 64'hAA, 1, 3, 0, A), 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk_vec(mk_in(0, 1, Z, 64'h0, 1, 3, 0, A), 0, 1, 64'h510, 64'hAA, 1, 64'hAA, 0);
    tbl[2] = mk_vec(mk_in(0, 1, Z, 64'h0, 1, 0, 0, A), 0, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk_vec(mk_in(1, 1, X, 64'h1, 0, 0, 0, X), 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk_vec(mk_in(1, 1, X, 64'h2, 0, 0, 0, X), 0, 0, 0, 0, 1, 64'h1, 0);
    tbl[5] = mk_vec(mk_in(0, 1, Z, 64'h0, 0, 0, 0, X), 0, 0, 0, 0, 1, 64'h2, 0);
    tbl[6] = mk_vec(mk_in(0, 1, Z, 64'h0, 1, 1, 0, X), 0, 1, 64'h1238, 64'h2, 1, 64'h2, 0);
    tbl[7] = mk_vec(mk_in(0, 1, Z, 64'h0, 1, 0, 0, X), 0, 0, 0, 0, 0, 0, 0);

    do_reset();

    // Directed table: single store round trip, then coalescing.
    foreach (tbl[k]) begin
      apply(tbl[k].i);
      chk($sformatf("tbl%0d_full", k), 64'(wb_full), 64'(tbl[k].full));
      chk($sformatf("tbl%0d_store", k), 64'(proc2mem_command == BUS_STORE), 64'(tbl[k].st));
      chk($sformatf("tbl%0d_paddr", k), proc2mem_addr, tbl[k].pa);
      chk($sformatf("tbl%0d_pdata", k), proc2mem_data, tbl[k].pd);
      chk($sformatf("tbl%0d_hit", k), 64'(rd_hit), 64'(tbl[k].hit));
      chk($sformatf("tbl%0d_rdata", k), rd_data, tbl[k].rd);
      chk($sformatf("tbl%0d_done", k), 64'(flush_done), 64'(tbl[k].done));
      tick();
    end

    // Fill to capacity, 5th push dropped, one accept frees a slot.
    do_reset();
    for (int unsigned k = 1; k <= 4; k++) begin
      apply(mk_in(1, 1, mka(k, k), 64'(k), 0, 0, 0, Z));
      tick();
    end
    apply(mk_in(1, 1, mka(9, 9), 64'h99, 0, 0, 0, mka(9, 9)));
    chk("full_after4", 64'(wb_full), 64'd1);
    tick();
    apply(mk_in(0, 1, Z, 0, 1, 1, 0, mka(9, 9)));
    chk("fifth_dropped", 64'(rd_hit), 64'd0);
    tick();
    apply(mk_in(0, 1, Z, 0, 0, 0, 0, Z));
    chk("full_after_accept", 64'(wb_full), 64'd0);
    tick();

    // Full buffer: push and accept in the same cycle, push still dropped.
    do_reset();
    for (int unsigned k = 1; k <= 4; k++) begin
      apply(mk_in(1, 1, mka(k, 1), 64'(k + 16), 0, 0, 0, Z));
      tick();
    end
    apply(mk_in(1, 1, mka(7, 7), 64'h77, 1, 2, 0, mka(7, 7)));
    tick();
    apply(mk_in(0, 1, Z, 0, 0, 0, 0, mka(7, 7)));
    chk("full_pushpop_dropped", 64'(rd_hit), 64'd0);
    tick();
    for (int unsigned k = 0; k < 3; k++) begin
      apply(mk_in(0, 1, Z, 0, 1, 1, 0, Z));
      chk($sformatf("drain3_store%0d", k), 64'(proc2mem_command), 64'(BUS_STORE));
      tick();
    end
    apply(mk_in(0, 1, Z, 0, 1, 1, 0, Z));
    chk("count3_empty", 64'(proc2mem_command), 64'(BUS_NONE));
    tick();

    // Flush with stalled responses; pushes rejected, done pulses once.
    do_reset();
    for (int unsigned k = 1; k <= 3; k++) begin
      apply(mk_in(1, 1, mka(k, 3), 64'(k + 32), 0, 0, 0, Z));
      tick();
    end
    done_cnt = 0;
    for (int unsigned k = 0; k <= 8; k++) begin
      apply(mk_in((k >= 1 && k <= 6) ? 1'b1 : 1'b0, 1, mka(k + 40, 4), 64'(k),
                  (k <= 6) ? 1'b1 : 1'b0, (k >= 3 && k <= 5) ? 4'h5 : 4'h0,
                  (k == 0) ? 1'b1 : 1'b0, mka(k + 40, 4)));
      if (k == 1) chk("flush_full", 64'(wb_full), 64'd1);
      if (k == 6) chk("flush_done_after_pop", 64'(flush_done), 64'd1);
      if (flush_done) done_cnt++;
      tick();
    end
    chk("flush_done_count", 64'(done_cnt), 64'd1);

    // Flush on an empty buffer completes on the next cycle.
    apply(mk_in(0, 1, Z, 0, 0, 0, 1, Z));
    tick();
    apply(mk_in(0, 1, Z, 0, 0, 0, 0, Z));
    chk("flush_empty_done", 64'(flush_done), 64'd1);
    tick();
    apply(mk_in(0, 1, Z, 0, 0, 0, 0, Z));
    chk("flush_empty_done_clear", 64'(flush_done), 64'd0);
    tick();

    // Asynchronous reset in the middle of an unacknowledged store.
    do_reset();
    apply(mk_in(1, 1, A, 64'h55, 0, 0, 0, A));
    tick();
    apply(mk_in(0, 1, Z, 0, 1, 0, 0, A));
    chk("pre_reset_store", 64'(proc2mem_command), 64'(BUS_STORE));
    #1 reset = 1'b0;
    #1;
    chk("rst_cmd_none", 64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_addr_zero", proc2mem_addr, 64'd0);
    chk("rst_rd_hit", 64'(rd_hit), 64'd0);
    chk("rst_full", 64'(wb_full), 64'd0);
    mq.delete();
    m_flush = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    apply(mk_in(0, 1, Z, 0, 1, 1, 0, A));
    chk("no_retry_after_reset", 64'(proc2mem_command), 64'(BUS_NONE));
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int unsigned n = 0; n < 400; n++) begin
      in_t x;
      x.en  = ($urandom_range(0, 1) == 1);
      x.vld = ($urandom_range(0, 9) < 8);
      x.dty = ($urandom_range(0, 9) < 8);
      x.a   = mka($urandom_range(0, 3), $urandom_range(0, 1));
      x.d   = {$urandom, $urandom};
      x.g   = ($urandom_range(0, 9) < 7);
      x.r   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      x.fl  = ($urandom_range(0, 99) < 3);
      x.ra  = mka($urandom_range(0, 3), $urandom_range(0, 1));
      apply(x);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
